// File: rtl/insn_queue_if.sv
// Fetch/decode handshake bundle for the pending instruction queue.
// The producer side (fetch plus decode control) uses master; the queue uses slave.
interface insn_queue_if #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              push;
  logic [DATA_W-1:0] in_insn;
  logic              next;
  logic              clear;
  logic [DATA_W-1:0] out_insn;
  logic              out_valid;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [CNT_W-1:0]  count;

  modport master (
    output push, in_insn, next, clear,
    input  out_insn, out_valid, empty, full, almost_full, count
  );

  modport slave (
    input  push, in_insn, next, clear,
    output out_insn, out_valid, empty, full, almost_full, count
  );
endinterface

// File: rtl/insn_queue.sv
// Pending instruction queue between fetch and decode. It uses all DEPTH slots
// and holds a registered head word that acts as the fetch/decode interstage buffer.
module insn_queue #(
  parameter int                DATA_W    = 24,
  parameter int                DEPTH     = 8,
  parameter int                AF_THRESH = 6,
  parameter logic [DATA_W-1:0] NOP_VALUE = 24'h00ff00
) (
  input logic         clk,
  input logic         rst,
  insn_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] out_insn_q, out_insn_d;
  logic              out_valid_q, out_valid_d;

  logic [CNT_W-1:0]  count;
  logic              is_empty, is_full;
  logic              do_push;

  // Flags come from the registered pointers only; the wrap bit separates full from empty.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_W'(DEPTH));
  assign do_push  = q.push && !is_full && !q.clear;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_insn_d  = out_insn_q;
    out_valid_d = out_valid_q;
    if (q.clear) begin
      wr_ptr_d    = rd_ptr_q;
      out_insn_d  = NOP_VALUE;
      out_valid_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (q.next) begin
        if (!is_empty) begin
          out_insn_d  = mem_q[rd_ptr_q[PTR_W-1:0]];
          rd_ptr_d    = rd_ptr_q + CNT_W'(1);
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_insn_q  <= NOP_VALUE;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_insn_q  <= out_insn_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= q.in_insn;
  end

  assign q.out_insn    = out_insn_q;
  assign q.out_valid   = out_valid_q;
  assign q.empty       = is_empty;
  assign q.full        = is_full;
  assign q.almost_full = (count >= CNT_W'(AF_THRESH));
  assign q.count       = count;
endmodule

// File: tb/tb_insn_queue.sv
// Directed self-checking bench for insn_queue: reset, fill, drain/wrap,
// simultaneous push/next and flush.
module tb_insn_queue;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  insn_queue_if #(.DATA_W(24), .DEPTH(8)) qi ();

  insn_queue #(
    .DATA_W(24), .DEPTH(8), .AF_THRESH(6), .NOP_VALUE(24'h00ff00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q  (qi.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Apply one cycle of inputs, clock it, and settle 1 time unit past the edge.
  task automatic step(input logic p, input logic [23:0] d, input logic n, input logic c);
    qi.push    = p;
    qi.in_insn = d;
    qi.next    = n;
    qi.clear   = c;
    @(posedge clk);
    #1;
    qi.push  = 1'b0;
    qi.next  = 1'b0;
    qi.clear = 1'b0;
  endtask

  initial begin
    logic [23:0] v;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    qi.push = 1'b0;
    qi.in_insn = '0;
    qi.next = 1'b0;
    qi.clear = 1'b0;
    #2;
    chk("rst_out_insn", 32'(qi.out_insn), 32'h00ff00);
    chk("rst_out_valid", 32'(qi.out_valid), 0);
    chk("rst_empty", 32'(qi.empty), 1);
    chk("rst_full", 32'(qi.full), 0);
    chk("rst_count", 32'(qi.count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, 0);
    chk("idle_out_insn", 32'(qi.out_insn), 32'h00ff00);
    chk("idle_empty", 32'(qi.empty), 1);

    // Async reset between edges with state in flight.
    step(1, 24'h0c00c0, 0, 0);
    step(1, 24'h0c00c1, 1, 0);
    chk("pre_arst_valid", 32'(qi.out_valid), 1);
    chk("pre_arst_count", 32'(qi.count), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(qi.count), 0);
    chk("arst_out_valid", 32'(qi.out_valid), 0);
    chk("arst_out_insn", 32'(qi.out_insn), 32'h00ff00);
    chk("arst_empty", 32'(qi.empty), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill to full, then one dropped push.
    for (int i = 0; i < 8; i++) begin
      v = 24'((i << 16) | i);
      step(1, v, 0, 0);
      chk("fill_count", 32'(qi.count), 32'(i + 1));
      chk("fill_af", 32'(qi.almost_full), (i + 1 >= 6) ? 1 : 0);
      chk("fill_full", 32'(qi.full), (i + 1 == 8) ? 1 : 0);
    end
    step(1, 24'h080008, 0, 0);
    chk("drop_count", 32'(qi.count), 8);
    chk("drop_full", 32'(qi.full), 1);

    // Drain in order, then next on empty.
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0);
      chk("drain_data", 32'(qi.out_insn), 32'((i << 16) | i));
      chk("drain_valid", 32'(qi.out_valid), 1);
    end
    chk("drain_empty", 32'(qi.empty), 1);
    step(0, 0, 1, 0);
    chk("under_valid", 32'(qi.out_valid), 0);
    chk("under_hold", 32'(qi.out_insn), 32'h070007);

    // Three more fill/drain rounds to wrap the pointers.
    for (int r = 1; r <= 3; r++) begin
      for (int i = 0; i < 8; i++) step(1, 24'((r << 20) | (i << 8) | i), 0, 0);
      chk("wrap_full", 32'(qi.full), 1);
      for (int i = 0; i < 8; i++) begin
        step(0, 0, 1, 0);
        chk("wrap_data", 32'(qi.out_insn), 32'((r << 20) | (i << 8) | i));
      end
      chk("wrap_empty", 32'(qi.empty), 1);
    end

    // Push with next while full: pop wins, push dropped.
    for (int i = 0; i < 8; i++) step(1, 24'((i << 16) | i), 0, 0);
    step(1, 24'h0a00aa, 1, 0);
    chk("sim_full_data", 32'(qi.out_insn), 32'h000000);
    chk("sim_full_count", 32'(qi.count), 7);
    for (int i = 1; i < 8; i++) step(0, 0, 1, 0);
    chk("sim_full_last", 32'(qi.out_insn), 32'h070007);
    chk("sim_full_empty", 32'(qi.empty), 1);

    // Push with next while empty: no bypass.
    step(1, 24'h0b00bb, 1, 0);
    chk("sim_empty_valid", 32'(qi.out_valid), 0);
    chk("sim_empty_count", 32'(qi.count), 1);
    step(0, 0, 1, 0);
    chk("sim_empty_data", 32'(qi.out_insn), 32'h0b00bb);
    chk("sim_empty_valid2", 32'(qi.out_valid), 1);

    // Flush with push and next also asserted.
    for (int i = 0; i < 6; i++) step(1, 24'(32'h0d0000 | i), 0, 0);
    step(0, 0, 1, 0);
    chk("pre_clr_count", 32'(qi.count), 5);
    chk("pre_clr_valid", 32'(qi.out_valid), 1);
    step(1, 24'h0e00ee, 1, 1);
    chk("clr_count", 32'(qi.count), 0);
    chk("clr_empty", 32'(qi.empty), 1);
    chk("clr_out_insn", 32'(qi.out_insn), 32'h00ff00);
    chk("clr_valid", 32'(qi.out_valid), 0);
    step(1, 24'h1290e0, 0, 0);
    chk("post_clr_count", 32'(qi.count), 1);
    step(0, 0, 1, 0);
    chk("post_clr_data", 32'(qi.out_insn), 32'h1290e0);
    chk("post_clr_valid", 32'(qi.out_valid), 1);
    chk("post_clr_empty", 32'(qi.empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/insn_queue.md
Name: insn_queue

Overview:
- Parametrised successor to the CPU's pending instruction queue. It sits between the fetch stage and decode.
- Fetch pushes {pc, insn} words. Decode pulls them into a registered output that acts as the fetch/decode interstage buffer.
- New capabilities:
  - full use of all DEPTH entries (no wasted slot)
  - occupancy count and almost_full
  - out_valid qualifier
  - flush that also invalidates the output buffer with a programmable NOP word

Parameters:
DATA_W, 24, width of one queue entry ({pc[7:0], insn[15:0]} in the current CPU)
DEPTH, 8, number of storage entries; power of two, >= 2
AF_THRESH, 6, almost_full asserts when count >= AF_THRESH; range 1..DEPTH
NOP_VALUE, 24'h00ff00, value loaded into out_insn on reset and on clear (MOV r15,r0 = nop)
CNT_W, $clog2(DEPTH)+1, width of count (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
push  in  1  write in_insn this cycle if !full
in_insn  in  DATA_W  entry to enqueue
next  in  1  advance: load oldest entry into out_insn if !empty
clear  in  1  flush all stored entries and invalidate output (jump redirect)
out_insn  out  DATA_W  registered head entry (interstage buffer)
out_valid  out  1  out_insn holds a real dequeued entry
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
count  out  CNT_W  stored entries, 0..DEPTH (excludes out_insn)

Behaviour:
- Storage: DEPTH x DATA_W array, not reset.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits. The extra bit is the wrap bit.
- count = wr_ptr - rd_ptr (modulo 2^CNT_W).
- empty, full, almost_full and count are combinational from the registered pointers only. They have no combinational path from push, next or clear.
- Async reset (rst high, independent of clk):
  - wr_ptr = rd_ptr = 0
  - out_insn = NOP_VALUE, out_valid = 0
  - so count = 0, empty = 1, full = 0, almost_full = 0
- Priority per rising edge: rst > clear > (push, next evaluated independently).
- clear (rst low):
  - wr_ptr <= rd_ptr, out_insn <= NOP_VALUE, out_valid <= 0.
  - push and next are ignored in that cycle; rd_ptr is unchanged.
  - The next cycle shows count = 0, empty = 1.
- next && !empty: out_insn <= mem[rd_ptr], rd_ptr <= rd_ptr+1, out_valid <= 1.
- next && empty: out_valid <= 0; out_insn and rd_ptr hold.
- !next: out_insn, out_valid and rd_ptr hold. Decode must treat a held out_valid=1 word as already consumed unless next was asserted.
- push && !full: mem[wr_ptr] <= in_insn, wr_ptr <= wr_ptr+1.
- push && full: the entry is dropped silently and wr_ptr holds. The producer must gate push with full.
- Simultaneous push and next:
  - Both are judged on pre-edge flags.
  - When full: the pop succeeds, the push is dropped, and count goes to DEPTH-1.
  - When empty: the push succeeds, next sees empty so out_valid <= 0, and count goes to 1. There is no write-to-read bypass.
  - Otherwise both proceed and count is unchanged.
- Latency: an entry pushed at edge N can appear on out_insn at edge N+1 at the earliest (next asserted in cycle N+1 pre-edge). Minimum push-to-output is 1 cycle.
- Pointer wrap: low bits index the array, the wrap bit distinguishes full from empty. Wrap-around past DEPTH entries is seamless.
- Reset mid-operation: any in-flight push or next is discarded, and all state returns to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset then idle → out_insn = 24'h00ff00, out_valid = 0, empty = 1, full = 0, count = 0. Assert rst asynchronously mid-cycle → same values immediately, without a clock edge.
- Fill: push 24'h000000..24'h070007 on 8 edges, next = 0 → count 1..8, almost_full rises when count = 6, full = 1 at count = 8. A 9th push of 24'h080008 is dropped (count stays 8).
- Drain and wrap:
  - From full, assert next 8 times → out_insn = 24'h000000..24'h070007 in order, out_valid = 1, empty = 1 after the 8th.
  - 9th next → out_valid = 0 and out_insn holds 24'h070007.
  - Repeat fill/drain 3 times to exercise pointer wrap; data must stay ordered.
- Simultaneous push/next:
  - At count = 8, push 24'h0a00aa with next → pop 24'h000000, push dropped, count = 7.
  - At count = 0, push 24'h0b00bb with next → out_valid = 0, count = 1. The next cycle's next yields 24'h0b00bb.
- Flush: with count = 5 and out_valid = 1, assert clear together with push and next → next cycle count = 0, empty = 1, out_insn = 24'h00ff00, out_valid = 0, rd_ptr unchanged. A subsequent push of 24'h1290e0 then next → out_insn = 24'h1290e0.
